// File: rtl/sobel_pkg.sv
// Shared constants and FSM encoding for the Sobel frame sequencer.
// Image geometry defaults, window layout and controller states.
package sobel_pkg;

  localparam int MAX_ROW_D = 480;
  localparam int MAX_COL_D = 640;
  localparam int ADDR_W_D  = 19;

  localparam int ROWCOL_W = 10;
  localparam int PIX_W    = 8;
  localparam int WIN_N    = 9;
  localparam int WIN_LAST = WIN_N - 1;
  localparam int WIN_W    = WIN_N * PIX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_FETCH,
    ST_COMPUTE,
    ST_WRITE,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sobel_frame_sequencer_fetch.sv
// 3x3 window read sequencer: nine reads on consecutive cycles,
// each captured one cycle later into its window slot.
module sobel_window_fetch
  import sobel_pkg::*;
#(
  parameter int MAX_COL = MAX_COL_D,
  parameter int ADDR_W  = ADDR_W_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                clear,
  input  logic [ROWCOL_W-1:0] row,
  input  logic [ROWCOL_W-1:0] col,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [PIX_W-1:0]    mem_rd_data,
  output logic [WIN_W-1:0]    win_pix,
  output logic                win_done
);

  logic [3:0]        k;
  logic [1:0]        dr;
  logic [1:0]        dc;
  logic [1:0]        nxt_dr;
  logic [1:0]        nxt_dc;
  logic              cap_en;
  logic [3:0]        cap_k;
  logic [ADDR_W-1:0] go_addr;
  logic [ADDR_W-1:0] step_addr;

  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [ROWCOL_W-1:0] r,
    input logic [ROWCOL_W-1:0] c,
    input logic [1:0]          d_r,
    input logic [1:0]          d_c
  );
    logic [ADDR_W-1:0] rr;
    logic [ADDR_W-1:0] cc;
    rr = ADDR_W'(r) + ADDR_W'(d_r) - ADDR_W'(1);
    cc = ADDR_W'(c) + ADDR_W'(d_c) - ADDR_W'(1);
    return rr * ADDR_W'(MAX_COL) + cc;
  endfunction

  // Next window offset in raster order and the matching read addresses.
  always_comb begin
    nxt_dr = dr;
    nxt_dc = dc + 2'd1;
    if (dc == 2'd2) begin
      nxt_dc = 2'd0;
      nxt_dr = dr + 2'd1;
    end
    go_addr   = addr_of(row, col, 2'd0, 2'd0);
    step_addr = addr_of(row, col, nxt_dr, nxt_dc);
  end

  // Read issue: one strobe per cycle for slots 0..8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      k           <= '0;
      dr          <= '0;
      dc          <= '0;
    end else if (clear) begin
      mem_rd_en <= 1'b0;
      k         <= '0;
      dr        <= '0;
      dc        <= '0;
    end else if (go) begin
      mem_rd_en   <= 1'b1;
      mem_rd_addr <= go_addr;
      k           <= '0;
      dr          <= '0;
      dc          <= '0;
    end else if (mem_rd_en) begin
      if (k == 4'(WIN_LAST)) begin
        mem_rd_en <= 1'b0;
      end else begin
        k           <= k + 4'd1;
        dr          <= nxt_dr;
        dc          <= nxt_dc;
        mem_rd_addr <= step_addr;
      end
    end
  end

  // Capture: read data lands one cycle after its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_en  <= 1'b0;
      cap_k   <= '0;
      win_pix <= '0;
    end else begin
      cap_en <= mem_rd_en && !clear;
      cap_k  <= k;
      if (cap_en && !clear) begin
        win_pix[{cap_k, 3'b000} +: PIX_W] <= mem_rd_data;
      end
    end
  end

  assign win_done = cap_en && (cap_k == 4'(WIN_LAST));

endmodule

// File: rtl/sobel_frame_sequencer.sv
// Frame controller: raster scan, border handling, window fetch,
// Sobel core handoff and output write handshake.
module sobel_frame_sequencer
  import sobel_pkg::*;
#(
  parameter int MAX_ROW = MAX_ROW_D,
  parameter int MAX_COL = MAX_COL_D,
  parameter int ADDR_W  = ADDR_W_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [ROWCOL_W-1:0] row,
  output logic [ROWCOL_W-1:0] col,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [PIX_W-1:0]    mem_rd_data,
  output logic                win_valid,
  output logic [WIN_W-1:0]    win_pix,
  input  logic                sobel_valid,
  input  logic [PIX_W-1:0]    sobel_pix,
  output logic                wr_valid,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [PIX_W-1:0]    wr_data,
  input  logic                wr_ready
);

  state_t            state;
  logic              abort_pend;
  logic              last_row;
  logic              last_col;
  logic              border;
  logic              fetch_go;
  logic              fetch_clear;
  logic              win_done;
  logic [ADDR_W-1:0] pix_addr;

  // Position decode and fetch control.
  always_comb begin
    last_row    = row == ROWCOL_W'(MAX_ROW - 1);
    last_col    = col == ROWCOL_W'(MAX_COL - 1);
    border      = (row == '0) || last_row || (col == '0) || last_col;
    pix_addr    = ADDR_W'(row) * ADDR_W'(MAX_COL) + ADDR_W'(col);
    fetch_go    = (state == ST_SETUP) && !border && !abort;
    fetch_clear = abort &&
      (state inside {ST_SETUP, ST_FETCH, ST_COMPUTE, ST_NEXT});
  end

  sobel_window_fetch #(
    .MAX_COL (MAX_COL),
    .ADDR_W  (ADDR_W)
  ) u_fetch (
    .clk         (clk),
    .rst_n       (rst_n),
    .go          (fetch_go),
    .clear       (fetch_clear),
    .row         (row),
    .col         (col),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .win_pix     (win_pix),
    .win_done    (win_done)
  );

  // Frame FSM with registered status, counters and write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_valid  <= 1'b0;
      wr_valid   <= 1'b0;
      abort_pend <= 1'b0;
      row        <= '0;
      col        <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      win_valid <= 1'b0;
      done      <= 1'b0;
      if (fetch_clear) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        row   <= '0;
        col   <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              busy  <= 1'b1;
              row   <= '0;
              col   <= '0;
              state <= ST_SETUP;
            end
          end
          ST_SETUP: begin
            if (border) begin
              wr_valid <= 1'b1;
              wr_addr  <= pix_addr;
              wr_data  <= '0;
              state    <= ST_WRITE;
            end else begin
              state <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            if (win_done) begin
              win_valid <= 1'b1;
              state     <= ST_COMPUTE;
            end
          end
          ST_COMPUTE: begin
            if (sobel_valid) begin
              wr_valid <= 1'b1;
              wr_addr  <= pix_addr;
              wr_data  <= sobel_pix;
              state    <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (abort) abort_pend <= 1'b1;
            if (wr_ready) begin
              wr_valid   <= 1'b0;
              abort_pend <= 1'b0;
              if (abort || abort_pend) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                row   <= '0;
                col   <= '0;
              end else begin
                state <= ST_NEXT;
              end
            end
          end
          ST_NEXT: begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row   <= '0;
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                row   <= row + ROWCOL_W'(1);
                state <= ST_SETUP;
              end
            end else begin
              col   <= col + ROWCOL_W'(1);
              state <= ST_SETUP;
            end
          end
          ST_DONE: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Bench for sobel_frame_sequencer on a 4x4 image: SRAM and Sobel
// core models plus a raster-order reference of the output frame.
module tb_sobel_frame_sequencer;

  localparam int MR = 4;
  localparam int MC = 4;
  localparam int AW = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic [9:0]  row;
  logic [9:0]  col;
  logic        mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = '0;
  logic        win_valid;
  logic [71:0] win_pix;
  logic        sobel_valid = 1'b0;
  logic [7:0]  sobel_pix = '0;
  logic        wr_valid;
  logic [AW-1:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ready = 1'b1;

  sobel_frame_sequencer #(
    .MAX_ROW (MR),
    .MAX_COL (MC),
    .ADDR_W  (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .row         (row),
    .col         (col),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .win_valid   (win_valid),
    .win_pix     (win_pix),
    .sobel_valid (sobel_valid),
    .sobel_pix   (sobel_pix),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int rdy_mode = 0;
  int sob_delay = 2;
  bit sob_rnd = 1'b0;
  bit stray_now = 1'b0;
  bit win_chk = 1'b1;
  int sob_cnt = 0;
  logic [7:0] sob_val = '0;
  logic [7:0] sob_next = '0;

  logic [7:0] sob_q[$];
  int rd_q[$];
  int rd_cyc[$];
  int win_cyc[$];
  int got_a[$];
  int got_d[$];
  int got_c[$];
  int win_cnt = 0;
  int done_cnt = 0;
  bit stall_prev = 1'b0;
  int prev_a = 0;
  int prev_d = 0;

  typedef struct {
    int delay;
    int rdy;
    bit rnd;
    int exp_writes;
    int exp_done;
    int exp_hi;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix_val(input int a);
    return (a * 16) % 256;
  endfunction

  function automatic bit is_border(input int r, input int c);
    return r == 0 || r == MR - 1 || c == 0 || c == MC - 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'(int'(mem_rd_addr) * 16);
  end

  always @(posedge clk) begin
    sobel_valid <= 1'b0;
    if (sob_cnt == 1) begin
      sobel_valid <= 1'b1;
      sobel_pix   <= sob_val;
    end
    if (stray_now) begin
      sobel_valid <= 1'b1;
      sobel_pix   <= 8'h77;
    end
    if (sob_cnt > 0) sob_cnt <= sob_cnt - 1;
    if (win_valid) begin
      sob_val <= sob_next;
      sob_cnt <= sob_delay;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) wr_ready = 1'b1;
      else if (rdy_mode == 1) wr_ready = ($urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_rd_en) begin
        rd_q.push_back(int'(mem_rd_addr));
        rd_cyc.push_back(cyc);
      end
      if (win_valid) begin
        win_cyc.push_back(cyc);
        if (sob_rnd) sob_next = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        else sob_next = 8'hFF;
        sob_q.push_back(sob_next);
        if (win_chk && win_cnt < (MR - 2) * (MC - 2)) begin
          int r;
          int c;
          r = 1 + win_cnt / (MC - 2);
          c = 1 + win_cnt % (MC - 2);
          for (int k = 0; k < 9; k++) begin
            chk("win_pix_slot", int'(win_pix[8*k +: 8]),
                pix_val((r + k / 3 - 1) * MC + (c + k % 3 - 1)));
          end
        end
        win_cnt++;
      end
      if (wr_valid && wr_ready) begin
        got_a.push_back(int'(wr_addr));
        got_d.push_back(int'(wr_data));
        got_c.push_back(cyc);
      end
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("stall_wr_valid", int'(wr_valid), 1);
        chk("stall_wr_addr", int'(wr_addr), prev_a);
        chk("stall_wr_data", int'(wr_data), prev_d);
      end
      stall_prev = wr_valid && !wr_ready;
      prev_a = int'(wr_addr);
      prev_d = int'(wr_data);
    end
  end

  task automatic clear_logs();
    sob_q.delete();
    rd_q.delete();
    rd_cyc.delete();
    win_cyc.delete();
    got_a.delete();
    got_d.delete();
    got_c.delete();
    win_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic start_frame();
    clear_logs();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    bit ok;
    ok = 1'b0;
    repeat (budget) begin
      @(negedge clk);
      if (done_cnt > 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("frame_complete", int'(ok), 1);
  endtask

  task automatic check_frame(input int exp_writes, input int exp_done,
                             input int exp_hi);
    int j;
    int hi;
    j = 0;
    hi = 0;
    chk("wr_count", got_a.size(), exp_writes);
    chk("done_count", done_cnt, exp_done);
    chk("window_count", sob_q.size(), (MR - 2) * (MC - 2));
    chk("read_count", rd_q.size(), 9 * (MR - 2) * (MC - 2));
    chk("busy_after", int'(busy), 0);
    for (int r = 0; r < MR; r++) begin
      for (int c = 0; c < MC; c++) begin
        int i;
        int ed;
        i = r * MC + c;
        if (is_border(r, c)) ed = 0;
        else begin
          ed = (j < sob_q.size()) ? int'(sob_q[j]) : -1;
          j++;
        end
        if (i < got_a.size()) begin
          chk("wr_addr_order", got_a[i], i);
          chk("wr_data_value", got_d[i], ed);
          if (got_d[i] == 255) hi++;
        end
      end
    end
    if (exp_hi >= 0) chk("interior_255", hi, exp_hi);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
    chk({tag, "_rd_addr"}, int'(mem_rd_addr), 0);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_pix_nz"}, int'(win_pix != '0), 0);
    chk({tag, "_wr_valid"}, int'(wr_valid), 0);
    chk({tag, "_wr_addr"}, int'(wr_addr), 0);
    chk({tag, "_wr_data"}, int'(wr_data), 0);
  endtask

  initial begin
    int snap;
    int n5;
    bit seen9;
    bit hit;

    vecs[0] = '{delay: 2, rdy: 0, rnd: 1'b0, exp_writes: 16, exp_done: 1, exp_hi: 4};
    vecs[1] = '{delay: 1, rdy: 1, rnd: 1'b1, exp_writes: 16, exp_done: 1, exp_hi: -1};
    vecs[2] = '{delay: 5, rdy: 1, rnd: 1'b1, exp_writes: 16, exp_done: 1, exp_hi: -1};
    vecs[3] = '{delay: 3, rdy: 0, rnd: 1'b1, exp_writes: 16, exp_done: 1, exp_hi: -1};

    repeat (3) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset asserted in the middle of a window fetch
    rdy_mode = 0;
    sob_delay = 2;
    sob_rnd = 1'b0;
    start_frame();
    hit = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (rd_q.size() > 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_fetch", int'(hit), 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midfetch_reset");
    snap = rd_q.size();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_reads_after_reset", rd_q.size(), snap);
    chk("idle_after_reset", int'(busy), 0);

    foreach (vecs[i]) begin
      sob_delay = vecs[i].delay;
      rdy_mode = vecs[i].rdy;
      sob_rnd = vecs[i].rnd;
      start_frame();
      wait_frame(3000);
      check_frame(vecs[i].exp_writes, vecs[i].exp_done, vecs[i].exp_hi);
      if (vecs[i].rdy == 0 && got_c.size() > 5 && win_cyc.size() > 0) begin
        chk("border_latency", got_c[1] - got_c[0], 3);
        chk("interior_latency", got_c[5] - win_cyc[0], sob_delay + 2);
      end
      if (i == 0 && rd_q.size() >= 9 && win_cyc.size() > 0) begin
        for (int k = 0; k < 9; k++) begin
          chk("rd_addr_p11", rd_q[k], (k / 3) * MC + (k % 3));
          chk("rd_spacing", rd_cyc[k] - rd_cyc[0], k);
        end
        chk("win_valid_timing", win_cyc[0] - rd_cyc[8], 2);
      end
    end

    // output port stalled at address 5
    rdy_mode = 2;
    wr_ready = 1'b1;
    sob_delay = 2;
    sob_rnd = 1'b0;
    start_frame();
    hit = 1'b0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (wr_valid && wr_addr == AW'(5)) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_addr5", int'(hit), 1);
    wr_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("hold_wr_valid", int'(wr_valid), 1);
      chk("hold_wr_addr", int'(wr_addr), 5);
      chk("hold_wr_data", int'(wr_data), 255);
    end
    @(posedge clk);
    #1 wr_ready = 1'b1;
    rdy_mode = 0;
    wait_frame(3000);
    n5 = 0;
    foreach (got_a[i]) if (got_a[i] == 5) n5++;
    chk("addr5_writes", n5, 1);
    check_frame(16, 1, 4);

    // abort while waiting on the core for pixel (2,1)
    sob_delay = 30;
    start_frame();
    hit = 1'b0;
    repeat (500) begin
      @(negedge clk);
      if (win_cnt == 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_p21", int'(hit), 1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_valid", int'(wr_valid), 0);
    repeat (40) @(negedge clk);
    seen9 = 1'b0;
    foreach (got_a[i]) if (got_a[i] == 9) seen9 = 1'b1;
    chk("abort_no_addr9", int'(seen9), 0);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", int'(busy), 0);
    sob_delay = 2;
    start_frame();
    wait_frame(3000);
    check_frame(16, 1, 4);

    // start while busy and a stray core strobe during fetch
    start_frame();
    hit = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (rd_q.size() > 0) begin
        hit = 1'b1;
        break;
      end
    end
    chk("reach_fetch2", int'(hit), 1);
    @(posedge clk);
    #1;
    start = 1'b1;
    stray_now = 1'b1;
    @(posedge clk);
    #1 stray_now = 1'b0;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_frame(3000);
    check_frame(16, 1, 4);

    // start and abort together in IDLE
    clear_logs();
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    chk("start_abort_reads", rd_q.size(), 0);
    chk("start_abort_writes", got_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
